stream_memory: RTL
==================

STREAM_MEMORY -- requirements
Module: stream_memory

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, which is the word width in bits and SHALL be a multiple of 8.
REQ-002 The block SHALL take parameter ADDR_W, default 8, which is the address width.
REQ-003 The block SHALL take parameter DEPTH, default 128, which is the number of words and SHALL satisfy DEPTH <= 2^ADDR_W.
REQ-004 The block SHALL have these ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- we  in  1  write strobe.
- write_addr  in  ADDR_W  write address.
- datai  in  DATA_W  write data.
- wmask  in  DATA_W/8  byte-enable mask; bit k enables byte k.
- re  in  1  read strobe.
- addr  in  ADDR_W  read address.
- datao  out  DATA_W  registered read data.
- rvalid  out  1  one-cycle pulse marking datao as valid.
- done  in  1  pulse that starts a dump of the whole array.
- clr  in  1  pulse that starts a zero-fill of the whole array.
- dump_data  out  DATA_W  word being streamed.
- dump_addr  out  ADDR_W  index of dump_data.
- dump_valid  out  1  stream valid.
- dump_ready  in  1  stream ready from the sink.
- dump_last  out  1  marks word DEPTH-1; qualified by dump_valid.
- busy  out  1  high in CLEAR or DUMP.
- err  out  1  one-cycle pulse on a rejected access.

Function
REQ-005 The FSM SHALL have three states: IDLE, CLEAR and DUMP.
REQ-006 In IDLE, clr=1 SHALL move the FSM to CLEAR and done=1 SHALL move it to DUMP; when both are high, clr SHALL win and done SHALL be dropped.
REQ-007 When done or clr arrives while busy=1, it SHALL be ignored, SHALL NOT be queued, and SHALL pulse err.
REQ-008 CLEAR SHALL write zero to word i, counting 0..DEPTH-1, one word per cycle, then return to IDLE; CLEAR SHALL last exactly DEPTH cycles.
REQ-009 DUMP timing: dump_valid SHALL rise on the cycle after done is accepted, with dump_addr=0 and dump_data=mem[0].
REQ-010 While dump_valid=1 and dump_ready=0, dump_data and dump_addr SHALL hold stable.
REQ-011 A transfer SHALL occur on a cycle with dump_valid=1 and dump_ready=1.
- The next word SHALL be presented on the following cycle, with no bubble.
- The transfer with dump_last=1 SHALL return the FSM to IDLE and drop dump_valid on the next cycle.
REQ-012 Writes in IDLE: on we=1 with write_addr < DEPTH, only the bytes enabled by wmask SHALL be updated at the clock edge.
REQ-013 A write with wmask of all zeros SHALL have no effect and SHALL NOT pulse err.
REQ-014 Writes while busy=1, and writes with write_addr >= DEPTH, SHALL be dropped and SHALL pulse err on the next cycle.
REQ-015 Reads are independent of FSM state: re=1 at edge N SHALL give datao and rvalid=1 at edge N+1.
- rvalid SHALL be 0 at every other edge.
- datao SHALL hold its last value while rvalid=0.
REQ-016 A read with addr >= DEPTH SHALL return datao=0 with rvalid=1 and SHALL pulse err.
REQ-017 A read and write to the same address in one cycle SHALL return the old data (read-first).
REQ-018 The dump stream SHALL reflect array contents at the time each word is fetched.

Reset
REQ-019 When rst=0, asynchronously:
- The FSM SHALL enter IDLE.
- The counters SHALL clear to 0.
- datao, rvalid, dump_data, dump_addr, dump_valid, dump_last, busy and err SHALL all be 0.
REQ-020 Array contents SHALL NOT be altered by reset.
REQ-021 Reset asserted during CLEAR SHALL leave a partially cleared array; reset during DUMP SHALL abort the stream without a dump_last transfer.
REQ-022 Operation SHALL resume on the first rising clk edge after rst returns to 1.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios:
- Byte-mask write: write 0xAABBCCDD to address 5 with wmask=1111, then write 0x11223344 to address 5 with wmask=0101, then read address 5 -> datao=0xAA22CC44 one cycle after re, with rvalid=1.
- Zero-fill: clr, then DEPTH cycles, then read any address -> busy high for exactly DEPTH cycles, then datao=0.
- Back-pressured dump: preload mem[i]=i, pulse done, hold dump_ready=0 for 3 cycles, then 1 -> dump_data stays 0 during the stall, then 128 words 0..127 are transferred with dump_last only on word 127 and busy falls afterwards.
- Rejected write: we to address 3 during DUMP -> err pulses for one cycle, and mem[3] is unchanged on a later read.
- Out-of-range and same-cycle collision: with DEPTH=100, read address 120 -> datao=0, rvalid=1, err=1; then read and write address 7 in the same cycle -> the read returns the old data.
- Mid-operation reset: rst=0 during DUMP at word 10 -> all outputs 0 immediately, the FSM is in IDLE, a new done restarts the dump at dump_addr=0, and earlier written data is intact.

Source files
------------

// File: rtl/stream_memory.sv
// Byte-masked single-write/single-read word memory with a zero-fill engine and a
// ready/valid dump stream that walks the whole array.
module stream_memory #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDR_W-1:0]   write_addr,
    input  logic [DATA_W-1:0]   datai,
    input  logic [DATA_W/8-1:0] wmask,
    input  logic                re,
    input  logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   datao,
    output logic                rvalid,
    input  logic                done,
    input  logic                clr,
    output logic [DATA_W-1:0]   dump_data,
    output logic [ADDR_W-1:0]   dump_addr,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic                dump_last,
    output logic                busy,
    output logic                err
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]  IDX0      = '0;

    typedef enum logic [1:0] {StIdle, StClear, StDump} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_any;
    logic              wr_en;
    logic              wr_rej;
    logic              cmd_rej;
    logic              xfer;
    logic [ADDR_W-1:0] cnt_nxt;

    always_comb begin
        wr_in_range = {1'b0, write_addr} < DEPTH_V;
        rd_in_range = {1'b0, addr} < DEPTH_V;
        wr_any      = |wmask;
        // An all-zero mask is a no-op, never an error.
        wr_en       = we && wr_any && wr_in_range && (state_q == StIdle);
        wr_rej      = we && wr_any && (!wr_in_range || (state_q != StIdle));
        cmd_rej     = (done || clr) && (state_q != StIdle);
        xfer        = dump_valid && dump_ready;
        cnt_nxt     = cnt_q + ADDR_W'(1);
    end

    // Array storage is deliberately outside reset.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[cnt_q[IDX_W-1:0]] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wmask[b]) begin
                    mem[write_addr[IDX_W-1:0]][8*b +: 8] <= datai[8*b +: 8];
                end
            end
        end
    end

    // Non-blocking read of mem gives read-first behaviour on a same-address write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            datao  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) begin
                datao <= rd_in_range ? mem[addr[IDX_W-1:0]] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else begin
            err <= wr_rej || (re && !rd_in_range) || cmd_rej;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            busy       <= 1'b0;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (clr) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                    end else if (done) begin
                        state_q    <= StDump;
                        cnt_q      <= '0;
                        busy       <= 1'b1;
                        dump_valid <= 1'b1;
                        dump_addr  <= '0;
                        dump_data  <= mem[IDX0];
                        dump_last  <= (DEPTH == 1);
                    end
                end
                StClear: begin
                    cnt_q <= cnt_nxt;
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        busy    <= 1'b0;
                    end
                end
                StDump: begin
                    if (xfer) begin
                        if (dump_last) begin
                            state_q    <= StIdle;
                            cnt_q      <= '0;
                            busy       <= 1'b0;
                            dump_valid <= 1'b0;
                            dump_last  <= 1'b0;
                        end else begin
                            // Fetch at advance time so the stream sees current contents.
                            cnt_q     <= cnt_nxt;
                            dump_addr <= cnt_nxt;
                            dump_data <= mem[cnt_nxt[IDX_W-1:0]];
                            dump_last <= (cnt_nxt == LAST_ADDR);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
